// File: rtl/prbs_checker_pkg.sv
// Shared constants for the PRBS generator/checker pair: state encoding and
// the default LFSR geometry both ends must agree on.
package prbs_checker_pkg;

  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_TAPS = 4'b1100;

endpackage

// File: rtl/prbs_checker_lfsr_predict.sv
// Next-bit prediction of a Fibonacci LFSR: parity of the tapped register bits.
module lfsr_predict
  import prbs_checker_pkg::*;
#(
  parameter int unsigned      WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
  input  logic [WIDTH-1:0] sr,
  output logic             pred
);

  assign pred = ^(sr & TAPS);

endmodule

// File: rtl/prbs_checker.sv
// Self-seeding PRBS checker: fills a local LFSR from the stream, verifies the
// seed, then counts mispredicted bits while locked.
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS),
  parameter int unsigned      LOCK_COUNT = 4,
  parameter int unsigned      LOSS_COUNT = 3,
  parameter int unsigned      ERR_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic                 in_bit,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_WIDTH-1:0] err_count,
  output logic [1:0]           state_dbg
);

  localparam int unsigned FW = $clog2(WIDTH);
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned LW = $clog2(LOSS_COUNT + 1);
  localparam logic [FW-1:0] FILL_LAST   = FW'(WIDTH - 1);
  localparam logic [MW-1:0] LOCK_TARGET = MW'(LOCK_COUNT);
  localparam logic [LW-1:0] LOSS_TARGET = LW'(LOSS_COUNT);

  logic [1:0]           state, state_d;
  logic [WIDTH-1:0]     sr, sr_d;
  logic [FW-1:0]        fill_cnt, fill_d;
  logic [MW-1:0]        match_cnt, match_d;
  logic [LW-1:0]        miss_cnt, miss_d;
  logic                 locked_d;
  logic                 err_hit;
  logic [ERR_WIDTH-1:0] err_base, err_d;
  logic                 pred;
  logic [WIDTH-1:0]     sr_from_line, sr_from_pred;

  lfsr_predict #(.WIDTH(WIDTH), .TAPS(TAPS)) u_predict (
    .sr   (sr),
    .pred (pred)
  );

  assign sr_from_line = {sr[WIDTH-2:0], in_bit};
  assign sr_from_pred = {sr[WIDTH-2:0], pred};

  // NOTE: every combinational output is defaulted first so no path infers a latch.
  always_comb begin
    state_d  = state;
    sr_d     = sr;
    fill_d   = fill_cnt;
    match_d  = match_cnt;
    miss_d   = miss_cnt;
    locked_d = locked;
    err_hit  = 1'b0;
    if (in_valid) begin
      case (state)
        SEARCH: begin
          sr_d = sr_from_line;
          if (fill_cnt == FILL_LAST) begin
            // An all-zero fill is the LFSR's lock-up state; start over.
            fill_d = '0;
            if (sr_from_line != '0) begin
              state_d = VERIFY;
              match_d = '0;
            end
          end else begin
            fill_d = fill_cnt + 1'b1;
          end
        end
        VERIFY: begin
          if (in_bit == pred) begin
            sr_d    = sr_from_line;
            match_d = match_cnt + 1'b1;
            if (match_d == LOCK_TARGET) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else begin
            state_d = SEARCH;
            fill_d  = '0;
          end
        end
        LOCKED: begin
          // Free-run on the prediction so line errors never corrupt the seed.
          sr_d = sr_from_pred;
          if (in_bit != pred) begin
            err_hit = 1'b1;
            miss_d  = miss_cnt + 1'b1;
            if (miss_d == LOSS_TARGET) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              fill_d   = '0;
              miss_d   = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          fill_d   = '0;
        end
      endcase
    end
  end

  // Clear takes effect first, so a coincident error leaves a count of one.
  assign err_base = clear_err ? '0 : err_count;
  assign err_d    = (err_hit && (err_base != '1)) ? err_base + 1'b1 : err_base;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEARCH;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_d;
      sr        <= sr_d;
      fill_cnt  <= fill_d;
      match_cnt <= match_d;
      miss_cnt  <= miss_d;
      locked    <= locked_d;
      err_pulse <= err_hit;
      err_count <= err_d;
    end
  end

  assign state_dbg = state;

endmodule
